// File: rtl/maquina_pkg.sv
// rtl/maquina_pkg.sv - shared coffee-machine sequencer state encodings
// Purpose: 4-bit state codes driven by the sequencer on its `state` bus.
//          Imported by the sequencer and by every block that decodes it.
// Ports:   none (package).
package maquina_pkg;

  localparam int SEQ_STATE_W = 4;

  localparam logic [SEQ_STATE_W-1:0] ST_IDLE                = 4'd1;
  localparam logic [SEQ_STATE_W-1:0] ST_VERIFICAR_AGUA      = 4'd3;
  localparam logic [SEQ_STATE_W-1:0] ST_ENCHER_RESERVATORIO = 4'd4;
  localparam logic [SEQ_STATE_W-1:0] ST_REALIZAR_EXTRACAO   = 4'd9;

endpackage

// File: rtl/nivel_debounce.sv
// rtl/nivel_debounce.sv - reservoir level threshold filter with hysteresis
// Purpose: turns raw level samples into a debounced `cheio` (full) bit.
//          While empty, DEBOUNCE_N consecutive valid samples >= NIVEL_CHEIO
//          set it; while full, DEBOUNCE_N consecutive valid samples
//          < NIVEL_RECARGA clear it. Levels in between never change it.
// Ports:   clk, reset (async, active-high)
//          nivel[LEVEL_W-1:0], nivel_valid : sensor sample and its strobe
//          cheio                            : debounced full flag
module nivel_debounce #(
  parameter int LEVEL_W       = 8,
  parameter int NIVEL_CHEIO   = 200,
  parameter int NIVEL_RECARGA = 150,
  parameter int DEBOUNCE_N    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] nivel,
  input  logic               nivel_valid,
  output logic               cheio
);

  localparam int CNT_W = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;

  localparam logic [LEVEL_W-1:0] CHEIO_L   = LEVEL_W'(NIVEL_CHEIO);
  localparam logic [LEVEL_W-1:0] RECARGA_L = LEVEL_W'(NIVEL_RECARGA);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_N - 1);

  logic             cheio_q, cheio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qualifica;

  always_comb begin
    cheio_d   = cheio_q;
    cnt_d     = cnt_q;
    // The sample that counts depends on which side of the hysteresis band we are on.
    qualifica = cheio_q ? (nivel < RECARGA_L) : (nivel >= CHEIO_L);
    if (nivel_valid) begin
      if (!qualifica) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cheio_d = ~cheio_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cheio_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cheio_q <= cheio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cheio = cheio_q;

endmodule

// File: rtl/controle_reservatorio.sv
// rtl/controle_reservatorio.sv - reservoir fill-pump controller
// Purpose: starts the fill pump when the sequencer passes through
//          ENCHER_RESERVATORIO with the reservoir not full, stops it on the
//          debounced full flag, and latches a fault if filling takes
//          FILL_TIMEOUT cycles without reaching full.
// Ports:   clk, reset (async, active-high)
//          state[3:0]                   : sequencer state bus
//          nivel[LEVEL_W-1:0], nivel_valid : level sensor sample and strobe
//          limpar_erro                  : one-cycle fault clear
//          agua_enchida                 : debounced full flag (masked in fault)
//          bomba                        : pump enable
//          erro_timeout                 : fill fault latched
module controle_reservatorio
  import maquina_pkg::*;
#(
  parameter int LEVEL_W       = 8,
  parameter int NIVEL_CHEIO   = 200,
  parameter int NIVEL_RECARGA = 150,
  parameter int DEBOUNCE_N    = 4,
  parameter int FILL_TIMEOUT  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         state,
  input  logic [LEVEL_W-1:0] nivel,
  input  logic               nivel_valid,
  input  logic               limpar_erro,
  output logic               agua_enchida,
  output logic               bomba,
  output logic               erro_timeout
);

  localparam int TIMER_W = $clog2(FILL_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(FILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ENCHENDO = 2'd1,
    FALHA    = 2'd2
  } bomba_fsm_e;

  bomba_fsm_e         fsm_q, fsm_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               cheio;

  nivel_debounce #(
    .LEVEL_W      (LEVEL_W),
    .NIVEL_CHEIO  (NIVEL_CHEIO),
    .NIVEL_RECARGA(NIVEL_RECARGA),
    .DEBOUNCE_N   (DEBOUNCE_N)
  ) u_nivel_debounce (
    .clk        (clk),
    .reset      (reset),
    .nivel      (nivel),
    .nivel_valid(nivel_valid),
    .cheio      (cheio)
  );

  always_comb begin
    fsm_d   = fsm_q;
    timer_d = timer_q;
    case (fsm_q)
      PARADO: begin
        if (state == ST_ENCHER_RESERVATORIO && !cheio) begin
          fsm_d   = ENCHENDO;
          timer_d = '0;
        end
      end
      ENCHENDO: begin
        // Saturate so the timer can never wrap back into a fresh window.
        if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TIMER_W'(1);
        end
        // Reaching full on the last allowed cycle still counts as success.
        if (cheio) begin
          fsm_d = PARADO;
        end else if (timer_q == TIMER_MAX) begin
          fsm_d = FALHA;
        end
      end
      FALHA: begin
        if (limpar_erro) begin
          fsm_d = PARADO;
        end
      end
      default: begin
        fsm_d = PARADO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= PARADO;
      timer_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      timer_q <= timer_d;
    end
  end

  // Decoded straight from registers so an async reset drops them at once.
  assign bomba        = (fsm_q == ENCHENDO);
  assign erro_timeout = (fsm_q == FALHA);
  assign agua_enchida = cheio && (fsm_q != FALHA);

endmodule

// File: tb/tb_controle_reservatorio.sv
// tb/tb_controle_reservatorio.sv - self-checking bench for controle_reservatorio
module tb_controle_reservatorio;

  localparam int LEVEL_W       = 8;
  localparam int NIVEL_CHEIO   = 200;
  localparam int NIVEL_RECARGA = 150;
  localparam int DEBOUNCE_N    = 4;
  localparam int FILL_TIMEOUT  = 1000;

  logic       clk;
  logic       reset;
  logic [3:0] state;
  logic [7:0] nivel;
  logic       nivel_valid;
  logic       limpar_erro;
  logic       agua_enchida;
  logic       bomba;
  logic       erro_timeout;

  int n_assert;
  int n_fail;

  // Reference model: reservoir "full" belief, run length of consecutive
  // samples arguing for the opposite belief, pump mode and cycles pumped.
  int m_full;
  int m_run;
  int m_mode;   // 0 idle, 1 pumping, 2 fault
  int m_pumped;

  controle_reservatorio #(
    .LEVEL_W      (LEVEL_W),
    .NIVEL_CHEIO  (NIVEL_CHEIO),
    .NIVEL_RECARGA(NIVEL_RECARGA),
    .DEBOUNCE_N   (DEBOUNCE_N),
    .FILL_TIMEOUT (FILL_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .nivel       (nivel),
    .nivel_valid (nivel_valid),
    .limpar_erro (limpar_erro),
    .agua_enchida(agua_enchida),
    .bomba       (bomba),
    .erro_timeout(erro_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full   = 0;
    m_run    = 0;
    m_mode   = 0;
    m_pumped = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bomba"}, bomba, logic'(m_mode == 1));
    chk({tag, ".erro_timeout"}, erro_timeout, logic'(m_mode == 2));
    chk({tag, ".agua_enchida"}, agua_enchida, logic'(m_full == 1 && m_mode != 2));
  endtask

  // One clock: apply inputs, advance the model with what the edge saw, check.
  task automatic tick(input int st, input int lvl, input bit vld, input bit clr,
                      input string tag);
    int  was_full;
    bit  wants_change;
    state       = 4'(st);
    nivel       = 8'(lvl);
    nivel_valid = vld;
    limpar_erro = clr;
    @(posedge clk);
    was_full = m_full;
    case (m_mode)
      0: if (st == 4 && was_full == 0) begin
           m_mode   = 1;
           m_pumped = 0;
         end
      1: begin
           m_pumped++;
           if (was_full == 1) m_mode = 0;
           else if (m_pumped == FILL_TIMEOUT) m_mode = 2;
         end
      default: if (clr) m_mode = 0;
    endcase
    if (vld) begin
      wants_change = (was_full == 1) ? (lvl < NIVEL_RECARGA) : (lvl >= NIVEL_CHEIO);
      if (wants_change) begin
        m_run++;
        if (m_run == DEBOUNCE_N) begin
          m_full = 1 - was_full;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int hi_cycles;
    int lvl_seq[8];
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    state       = 4'd1;
    nivel       = 8'd0;
    nivel_valid = 1'b0;
    limpar_erro = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.bomba", bomba, 1'b0);
    chk("reset.erro_timeout", erro_timeout, 1'b0);
    chk("reset.agua_enchida", agua_enchida, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Fill start and stop on full detection.
    tick(4, 100, 1, 0, "start");
    chk("start.bomba_next_edge", bomba, 1'b1);
    repeat (3) tick(1, 100, 1, 0, "fill_low");
    for (int i = 0; i < 3; i++) tick(3 + (i % 2), 210, 1, 0, "fill_full");
    chk("fill.agua_before_4th", agua_enchida, 1'b0);
    tick(1, 210, 1, 0, "fill_4th");
    chk("fill.agua_on_4th", agua_enchida, 1'b1);
    chk("fill.bomba_still_on", bomba, 1'b1);
    tick(1, 210, 1, 0, "fill_after");
    chk("fill.bomba_off", bomba, 1'b0);

    // Hysteresis: mid-band levels never clear full; four lows do.
    repeat (10) tick(1, 170, 1, 0, "hyst_mid");
    chk("hyst.agua_held", agua_enchida, 1'b1);
    repeat (3) tick(1, 140, 1, 0, "hyst_low");
    chk("hyst.agua_before_4th", agua_enchida, 1'b1);
    tick(1, 140, 1, 0, "hyst_low4");
    chk("hyst.agua_cleared", agua_enchida, 1'b0);

    // Interrupted run with valid gaps: only the 8th sample completes it.
    lvl_seq = '{210, 210, 210, 120, 210, 210, 210, 210};
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(2, 0)) tick(1, $urandom_range(255, 0), 0, 0, "gap");
      tick(1, lvl_seq[i], 1, 0, "restart");
      if (i == 6) chk("restart.agua_before_8th", agua_enchida, 1'b0);
    end
    chk("restart.agua_on_8th", agua_enchida, 1'b1);
    repeat (4) tick(1, 100, 1, 0, "drain");

    // Timeout: pump stays on exactly FILL_TIMEOUT cycles.
    tick(4, 100, 1, 0, "to_start");
    hi_cycles = 0;
    for (int i = 0; i < FILL_TIMEOUT + 5; i++) begin
      if (bomba) hi_cycles++;
      tick((i % 7 == 0) ? 4 : 3, 100, 1, 0, "to_run");
    end
    n_assert++;
    assert (hi_cycles == FILL_TIMEOUT) else begin
      n_fail++;
      $error("FAIL timeout.bomba_cycles observed=%0d expected=%0d", hi_cycles, FILL_TIMEOUT);
    end
    chk("timeout.erro", erro_timeout, 1'b1);
    repeat (6) tick(1, 210, 1, 0, "to_full_masked");
    chk("timeout.agua_masked", agua_enchida, 1'b0);
    tick(1, 210, 1, 1, "to_clear");
    chk("timeout.erro_cleared", erro_timeout, 1'b0);
    chk("timeout.agua_unmasked", agua_enchida, 1'b1);
    repeat (3) tick(1, 210, 1, 0, "to_idle");
    chk("timeout.bomba_idle", bomba, 1'b0);
    repeat (4) tick(1, 100, 1, 0, "to_drain");

    // Full detection on the same edge the timer reaches its last value.
    tick(4, 100, 1, 0, "tie_start");
    for (int k = 1; k < FILL_TIMEOUT; k++)
      tick(1, (k >= FILL_TIMEOUT - DEBOUNCE_N) ? 210 : 100, 1, 0, "tie_run");
    chk("tie.bomba_last_cycle", bomba, 1'b1);
    tick(1, 210, 1, 0, "tie_edge");
    chk("tie.bomba_off", bomba, 1'b0);
    chk("tie.no_erro", erro_timeout, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(3, 0) == 0) ? 4 : $urandom_range(9, 1),
           $urandom_range(255, 0), 1'($urandom_range(1, 0)),
           ($urandom_range(15, 0) == 0), "rand");

    // Async reset mid-fill.
    repeat (DEBOUNCE_N) tick(1, 140, 1, 1, "pre_rst");
    tick(4, 100, 1, 0, "rst_fill");
    repeat (5) tick(1, 100, 1, 0, "rst_run");
    chk("rst.bomba_running", bomba, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst.bomba_async", bomba, 1'b0);
    chk("rst.erro_async", erro_timeout, 1'b0);
    chk("rst.agua_async", agua_enchida, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (DEBOUNCE_N - 1) tick(1, 210, 1, 0, "rst_refill");
    chk("rst.agua_needs_n", agua_enchida, 1'b0);
    tick(1, 210, 1, 0, "rst_refill_n");
    chk("rst.agua_after_n", agua_enchida, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
